intraloop: RTL and testbench
============================

Name: intraloop

Overview:
Closed-loop H.264 intra 4x4 luma predictor. It accepts one 4x4 block per enabled cycle, addressed by packed {row, col}, in raster order. For each block it builds Vertical, Horizontal and DC predictions from stored neighbour pixels, picks the mode with minimum SAD, and writes the block's pixels back into its neighbour store for later blocks. It sits between the frame block scanner and the residual/entropy stages.

Parameters:
WIDTH, 1280, frame width in luma pixels (multiple of 4).
LENGTH, 720, frame height in luma pixels (multiple of 4).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
enable  input  1  block-valid strobe; one block processed per cycle while high.
mbnumber  input  32  {row[31:16], col[15:0]}: pixel coordinates of the block's top-left pixel.
cur_pix  input  128  original block pixels; pixel (y,x) is at bits [8*(4y+x) +: 8].
valid  output  1  result strobe.
pred_mode  output  2  selected mode: 0=Vertical, 1=Horizontal, 2=DC.
pred_pix  output  128  predicted block, same packing as cur_pix.
sad  output  12  SAD of cur_pix vs pred_pix (max 4080).
blk_row  output  16  row of the reported block.
blk_col  output  16  col of the reported block.

Behaviour:
- Reset (asynchronous): valid=0, pred_mode=2, pred_pix=0, sad=0, blk_row=0, blk_col=0. The neighbour store does not need a reset, because availability is derived from position only.
- Block acceptance: a block is accepted on a rising edge where enable=1, row<LENGTH and col<WIDTH.
  - row and col bits [1:0] are ignored (forced to 0).
  - Out-of-frame positions are dropped: valid=0 and the store is unchanged.
- Latency: 1 cycle. Prediction, SAD and mode selection are combinational from cur_pix and the store. All outputs are registered on the accepting edge. valid is high for exactly the cycle after each accepted block and low otherwise.
- Neighbour store:
  - Top line buffer: WIDTH x 8 bits, indexed by pixel column. Holds the bottom row of the block above.
  - Left column: 4 x 8 bits. Holds the rightmost column of the previously accepted block.
  - On accept, top[col..col+3] <= cur_pix row 3, and left[0..3] <= cur_pix column 3. This is the lossless reconstruction loop: reconstructed equals original.
  - Reads occur before writes in the same cycle.
- Availability:
  - top_avail = (row != 0).
  - left_avail = (col != 0). This is independent of whether the preceding block was actually accepted.
- Predictions:
  - V: every row equals T[0..3]. Available only if top_avail.
  - H: every column equals L[0..3]. Available only if left_avail.
  - DC, both available: (sumT+sumL+4)>>3.
  - DC, top only: (sumT+2)>>2.
  - DC, left only: (sumL+2)>>2.
  - DC, none available: 128. DC is always available.
- Selection: minimum SAD among available modes. Ties resolve to the lowest mode number (V, then H, then DC).
- Arithmetic: neighbour sums are 10-bit. Per-pixel absolute differences are 8-bit unsigned. The SAD accumulates in 12 bits without saturation.
- Enable low: outputs hold their values, except valid, which goes to 0.
- Reset mid-stream: the in-flight result is lost. The next accepted block uses position-based availability; store contents may be stale but are never used for row 0 or col 0.

Decomposition:
- Package intraloop_pkg holds:
  - mode typedef: enum logic[1:0] {MODE_V=0, MODE_H=1, MODE_DC=2}.
  - PIX_W=8, BLK=4, SAD_W=12.
  - pixel/block pack/unpack helper functions.
- Sub-module intra4x4_pred is combinational. It takes T[4], L[4], top_avail, left_avail and cur_pix, and produces the three predictions, their SADs and the selected mode/pred/sad.
- intraloop holds position decode, neighbour store and output registers.

Test Plan:
- Reset asserted mid-run -> all outputs reset immediately, with no clk edge. After release, block (0,0) -> pred_mode=2, pred_pix all 128.
- Block (0,0) with cur_pix all 0x80 -> valid next cycle, pred_mode=2, sad=0. Block (0,0) with all 0x00 -> pred_mode=2, sad=2048.
- Block (0,0) column 3 = 10,20,30,40, then block (0,4) with rows constant 10/20/30/40 -> pred_mode=1, sad=0.
- Full row 0 of all 0x50, then block (4,0) all 0x50 -> pred_mode=0, sad=0. Tie against DC also gives 0, and mode 0 wins.
- Block (4,4) with top=8 (all), left=16 (all), cur all 12 -> V sad=64, H sad=64, DC=(32+64+4)>>3=12 sad=0 -> pred_mode=2.
- Raster scan with mbnumber row=720 (=LENGTH) or col=1280 -> valid stays 0, store unchanged. enable=0 cycles -> valid=0.

Source files
------------

// File: rtl/intraloop_pkg.sv
// Shared types, sizes and pixel helpers for the intra 4x4 luma predictor.
// The prediction core and the loop wrapper both import this package.
package intraloop_pkg;

    localparam int PIX_W = 8;
    localparam int BLK   = 4;
    localparam int SAD_W = 12;
    localparam int BLK_W = PIX_W * BLK * BLK;

    typedef enum logic [1:0] {
        MODE_V  = 2'd0,
        MODE_H  = 2'd1,
        MODE_DC = 2'd2
    } mode_t;

    // Pixel (y,x) of a packed 4x4 block lives at bits [8*(4y+x) +: 8].
    function automatic logic [PIX_W-1:0] get_pix(input logic [BLK_W-1:0] blk,
                                                 input int y, input int x);
        return blk[PIX_W*(BLK*y+x) +: PIX_W];
    endfunction

    function automatic logic [BLK_W-1:0] put_pix(input logic [BLK_W-1:0] blk,
                                                 input int y, input int x,
                                                 input logic [PIX_W-1:0] val);
        logic [BLK_W-1:0] res;
        res = blk;
        res[PIX_W*(BLK*y+x) +: PIX_W] = val;
        return res;
    endfunction

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/intra4x4_pred.sv
// Combinational V/H/DC predictions for one 4x4 block, their SADs, and the
// minimum-SAD choice with ties going to the lowest mode number.
module intra4x4_pred
    import intraloop_pkg::*;
(
    input  logic [PIX_W-1:0] top_pix [BLK],
    input  logic [PIX_W-1:0] left_pix [BLK],
    input  logic             top_avail,
    input  logic             left_avail,
    input  logic [BLK_W-1:0] cur_pix,
    output logic [BLK_W-1:0] pred_v,
    output logic [BLK_W-1:0] pred_h,
    output logic [BLK_W-1:0] pred_dc,
    output logic [SAD_W-1:0] sad_v,
    output logic [SAD_W-1:0] sad_h,
    output logic [SAD_W-1:0] sad_dc,
    output mode_t            sel_mode,
    output logic [BLK_W-1:0] sel_pix,
    output logic [SAD_W-1:0] sel_sad
);

    logic [9:0]       sum_t;
    logic [9:0]       sum_l;
    logic [10:0]      sum_tl;
    logic [PIX_W-1:0] dc_val;

    always_comb begin
        sum_t = '0;
        sum_l = '0;
        for (int i = 0; i < BLK; i++) begin
            sum_t = sum_t + 10'(top_pix[i]);
            sum_l = sum_l + 10'(left_pix[i]);
        end
        sum_tl = 11'(sum_t) + 11'(sum_l) + 11'd4;
        if (top_avail && left_avail)
            dc_val = sum_tl[10:3];
        else if (top_avail)
            dc_val = 8'((sum_t + 10'd2) >> 2);
        else if (left_avail)
            dc_val = 8'((sum_l + 10'd2) >> 2);
        else
            dc_val = 8'd128;
    end

    for (genvar gi = 0; gi < BLK * BLK; gi++) begin : g_pix
        assign pred_v[PIX_W*gi +: PIX_W]  = top_pix[gi % BLK];
        assign pred_h[PIX_W*gi +: PIX_W]  = left_pix[gi / BLK];
        assign pred_dc[PIX_W*gi +: PIX_W] = dc_val;
    end

    // 16 * 255 = 4080 fits in 12 bits, so no saturation is needed.
    always_comb begin
        sad_v  = '0;
        sad_h  = '0;
        sad_dc = '0;
        for (int y = 0; y < BLK; y++) begin
            for (int x = 0; x < BLK; x++) begin
                sad_v  = sad_v  + SAD_W'(abs_diff(get_pix(cur_pix, y, x), get_pix(pred_v, y, x)));
                sad_h  = sad_h  + SAD_W'(abs_diff(get_pix(cur_pix, y, x), get_pix(pred_h, y, x)));
                sad_dc = sad_dc + SAD_W'(abs_diff(get_pix(cur_pix, y, x), dc_val));
            end
        end
    end

    // Start from DC and let lower-numbered modes take over on <=, so ties favour V then H.
    always_comb begin
        sel_mode = MODE_DC;
        sel_pix  = pred_dc;
        sel_sad  = sad_dc;
        if (left_avail && (sad_h <= sel_sad)) begin
            sel_mode = MODE_H;
            sel_pix  = pred_h;
            sel_sad  = sad_h;
        end
        if (top_avail && (sad_v <= sel_sad)) begin
            sel_mode = MODE_V;
            sel_pix  = pred_v;
            sel_sad  = sad_v;
        end
    end

endmodule

// File: rtl/intraloop.sv
// Closed-loop intra 4x4 predictor: position decode, neighbour store fed back
// from the accepted original pixels, and registered one-cycle result.
module intraloop
    import intraloop_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int LENGTH = 720
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [31:0]        mbnumber,
    input  logic [BLK_W-1:0]   cur_pix,
    output logic               valid,
    output logic [1:0]         pred_mode,
    output logic [BLK_W-1:0]   pred_pix,
    output logic [SAD_W-1:0]   sad,
    output logic [15:0]        blk_row,
    output logic [15:0]        blk_col
);

    localparam int           WORDS    = WIDTH / BLK;
    localparam int           IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [15:0]  WIDTH16  = 16'(WIDTH);
    localparam logic [15:0]  LENGTH16 = 16'(LENGTH);

    logic [15:0]        row;
    logic [15:0]        col;
    logic               accept;
    logic [IDX_W-1:0]   word_idx;

    assign row      = {mbnumber[31:18], 2'b00};
    assign col      = {mbnumber[15:2], 2'b00};
    assign accept   = enable && (row < LENGTH16) && (col < WIDTH16);
    assign word_idx = col[IDX_W+1:2];

    // Top line buffer: one 32-bit word per block column, holding 4 pixels.
    logic [4*PIX_W-1:0] top_mem [WORDS];
    logic [4*PIX_W-1:0] top_word;
    logic [PIX_W-1:0]   top_pix [BLK];
    logic [PIX_W-1:0]   left_pix [BLK];

    assign top_word = top_mem[word_idx];

    for (genvar gi = 0; gi < BLK; gi++) begin : g_top
        assign top_pix[gi] = top_word[PIX_W*gi +: PIX_W];
    end

    // Store needs no reset: availability comes from position, never from contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            top_mem[word_idx] <= cur_pix[BLK_W-1 -: 4*PIX_W];
            for (int i = 0; i < BLK; i++)
                left_pix[i] <= get_pix(cur_pix, i, BLK - 1);
        end
    end

    logic [BLK_W-1:0] pred_v;
    logic [BLK_W-1:0] pred_h;
    logic [BLK_W-1:0] pred_dc;
    logic [SAD_W-1:0] sad_v;
    logic [SAD_W-1:0] sad_h;
    logic [SAD_W-1:0] sad_dc;
    mode_t            sel_mode;
    logic [BLK_W-1:0] sel_pix;
    logic [SAD_W-1:0] sel_sad;

    intra4x4_pred u_pred (
        .top_pix    (top_pix),
        .left_pix   (left_pix),
        .top_avail  (row != 16'd0),
        .left_avail (col != 16'd0),
        .cur_pix    (cur_pix),
        .pred_v     (pred_v),
        .pred_h     (pred_h),
        .pred_dc    (pred_dc),
        .sad_v      (sad_v),
        .sad_h      (sad_h),
        .sad_dc     (sad_dc),
        .sel_mode   (sel_mode),
        .sel_pix    (sel_pix),
        .sel_sad    (sel_sad)
    );

    logic             valid_reg;
    mode_t            mode_reg;
    logic [BLK_W-1:0] pix_reg;
    logic [SAD_W-1:0] sad_reg;
    logic [15:0]      row_reg;
    logic [15:0]      col_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            mode_reg  <= MODE_DC;
            pix_reg   <= '0;
            sad_reg   <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
        end else begin
            valid_reg <= accept;
            if (accept) begin
                mode_reg <= sel_mode;
                pix_reg  <= sel_pix;
                sad_reg  <= sel_sad;
                row_reg  <= row;
                col_reg  <= col;
            end
        end
    end

    assign valid     = valid_reg;
    assign pred_mode = mode_reg;
    assign pred_pix  = pix_reg;
    assign sad       = sad_reg;
    assign blk_row   = row_reg;
    assign blk_col   = col_reg;

endmodule

// File: tb/tb_intraloop.sv
// Randomized and directed checks of intraloop against an array-based model
// of the neighbour store and the three intra 4x4 predictions.
module tb_intraloop;

    localparam int W = 1280;
    localparam int L = 720;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [31:0]  mbnumber;
    logic [127:0] cur_pix;
    logic         valid;
    logic [1:0]   pred_mode;
    logic [127:0] pred_pix;
    logic [11:0]  sad;
    logic [15:0]  blk_row;
    logic [15:0]  blk_col;

    intraloop #(.WIDTH(W), .LENGTH(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mbnumber  (mbnumber),
        .cur_pix   (cur_pix),
        .valid     (valid),
        .pred_mode (pred_mode),
        .pred_pix  (pred_pix),
        .sad       (sad),
        .blk_row   (blk_row),
        .blk_col   (blk_col)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference neighbour store and expected (held) outputs.
    int           ref_top [W];
    int           ref_left [4];
    int           exp_mode;
    logic [127:0] exp_pix;
    int           exp_sad;
    int           exp_row;
    int           exp_col;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int px(input logic [127:0] b, input int y, input int x);
        return int'(b[8*(4*y+x) +: 8]);
    endfunction

    task automatic model_predict(input int r, input int c, input logic [127:0] cur,
                                 output int m_best, output logic [127:0] p_best, output int s_best);
        int st, sl, dc, s, v;
        bit avail;
        logic [127:0] p;
        st = 0; sl = 0;
        for (int i = 0; i < 4; i++) begin
            st += ref_top[c+i];
            sl += ref_left[i];
        end
        if (r != 0 && c != 0) dc = (st + sl + 4) / 8;
        else if (r != 0)      dc = (st + 2) / 4;
        else if (c != 0)      dc = (sl + 2) / 4;
        else                  dc = 128;
        s_best = 1 << 30; m_best = -1; p_best = '0;
        for (int m = 0; m < 3; m++) begin
            avail = (m == 0) ? (r != 0) : (m == 1) ? (c != 0) : 1'b1;
            if (avail) begin
                s = 0; p = '0;
                for (int y = 0; y < 4; y++)
                    for (int x = 0; x < 4; x++) begin
                        v = (m == 0) ? ref_top[c+x] : (m == 1) ? ref_left[y] : dc;
                        p[8*(4*y+x) +: 8] = 8'(v);
                        s += (px(cur, y, x) > v) ? px(cur, y, x) - v : v - px(cur, y, x);
                    end
                if (s < s_best) begin
                    s_best = s; m_best = m; p_best = p;
                end
            end
        end
    endtask

    task automatic do_block(input bit en, input int r_in, input int c_in, input logic [127:0] pix);
        int r, c, m, s;
        bit acc;
        logic [127:0] p;
        r = r_in & 32'hFFFC;
        c = c_in & 32'hFFFC;
        acc = en && (r < L) && (c < W);
        if (acc) begin
            model_predict(r, c, pix, m, p, s);
            exp_mode = m; exp_pix = p; exp_sad = s; exp_row = r; exp_col = c;
        end
        @(negedge clk);
        enable   = en;
        mbnumber = {16'(r_in), 16'(c_in)};
        cur_pix  = pix;
        @(posedge clk);
        #1;
        $display("blk en=%0d row=%0d col=%0d acc=%0d valid=%0d mode=%0d sad=%0d", en, r_in, c_in, acc, valid, pred_mode, sad);
        check_value("valid", 128'(valid), 128'(acc));
        check_value("pred_mode", 128'(pred_mode), 128'(exp_mode));
        check_value("sad", 128'(sad), 128'(exp_sad));
        if (acc) begin
            check_value("pred_pix", pred_pix, exp_pix);
            check_value("blk_row", 128'(blk_row), 128'(exp_row));
            check_value("blk_col", 128'(blk_col), 128'(exp_col));
            for (int i = 0; i < 4; i++) begin
                ref_top[c+i] = px(pix, 3, i);
                ref_left[i]  = px(pix, i, 3);
            end
        end
        @(negedge clk);
        enable = 1'b0;
    endtask

    function automatic logic [127:0] fill(input int v);
        logic [127:0] b;
        for (int i = 0; i < 16; i++) b[8*i +: 8] = 8'(v);
        return b;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_valid"}, 128'(valid), 128'd0);
        check_value({tag, "_mode"}, 128'(pred_mode), 128'd2);
        check_value({tag, "_pix"}, pred_pix, 128'd0);
        check_value({tag, "_sad"}, 128'(sad), 128'd0);
        check_value({tag, "_row"}, 128'(blk_row), 128'd0);
        check_value({tag, "_col"}, 128'(blk_col), 128'd0);
        exp_mode = 2; exp_pix = '0; exp_sad = 0; exp_row = 0; exp_col = 0;
    endtask

    initial begin
        logic [127:0] b;
        int pr, pc, sel, base;
        for (int i = 0; i < W; i++) ref_top[i] = 0;
        for (int i = 0; i < 4; i++) ref_left[i] = 0;
        reset = 1'b1; enable = 1'b0; mbnumber = '0; cur_pix = '0;
        #12;
        check_reset_outputs("rst_init");
        @(negedge clk);
        reset = 1'b0;

        // DC-only corner block.
        do_block(1, 0, 0, fill(8'h80));
        check_value("dc80_mode", 128'(pred_mode), 128'd2);
        check_value("dc80_sad", 128'(sad), 128'd0);
        do_block(1, 0, 0, fill(0));
        check_value("dc00_sad", 128'(sad), 128'd2048);

        // Horizontal from the left column of the previous block.
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) b[8*(4*y+x) +: 8] = 8'(10 * (y + 1));
        do_block(1, 0, 0, b);
        do_block(1, 0, 4, b);
        check_value("h_mode", 128'(pred_mode), 128'd1);
        check_value("h_sad", 128'(sad), 128'd0);

        // Vertical beats DC on a tie.
        for (int c = 0; c < W; c += 4) do_block(1, 0, c, fill(8'h50));
        do_block(1, 4, 0, fill(8'h50));
        check_value("v_mode", 128'(pred_mode), 128'd0);
        check_value("v_sad", 128'(sad), 128'd0);

        // DC with both neighbours.
        do_block(1, 0, 4, fill(8));
        do_block(1, 4, 0, fill(16));
        do_block(1, 4, 4, fill(12));
        check_value("dc_both_mode", 128'(pred_mode), 128'd2);
        check_value("dc_both_pix", pred_pix, fill(12));

        // Out-of-frame and idle cycles must not touch the store.
        do_block(1, L, 8, fill(8'hFF));
        do_block(1, 4, W, fill(8'hFF));
        do_block(1, L + 3, 0, fill(8'hFF));
        do_block(0, 4, 8, fill(8'hFF));
        do_block(1, 4, 8, fill(12));
        check_value("drop_h_mode", 128'(pred_mode), 128'd1);
        check_value("drop_h_sad", 128'(sad), 128'd0);

        // Asynchronous reset mid-stream, away from any clock edge.
        do_block(1, 8, 8, fill(77));
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        do_block(1, 0, 0, fill(90));
        check_value("post_rst_pix", pred_pix, fill(128));

        // Random raster-ish traffic with occasional jumps, drops and gaps.
        pr = 0; pc = 4;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 16; i++) b[8*i +: 8] = 8'($urandom);
            end else begin
                base = $urandom_range(0, 252);
                for (int i = 0; i < 16; i++) b[8*i +: 8] = 8'(base + $urandom_range(0, 3));
            end
            sel = $urandom_range(0, 9);
            if (sel < 7) begin
                do_block(1, pr + $urandom_range(0, 3), pc + $urandom_range(0, 3), b);
                pc += 4;
                if (pc >= W) begin pc = 0; pr += 4; end
            end else if (sel == 7) begin
                do_block(0, pr, pc, b);
            end else if (sel == 8) begin
                do_block(1, L + $urandom_range(0, 100), $urandom_range(0, W - 1), b);
            end else begin
                do_block(1, 4 * $urandom_range(0, 3), 4 * $urandom_range(0, W / 4 - 1), b);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
